hz_tick_prescaler: RTL



---
 rtl/hz_pkg.sv | 15 +
 rtl/hz_tick_prescaler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hz_pkg.sv
// Shared definitions for the 1 Hz prescaler and the clock-source multiplexer stage.
// State encoding covers PAUSE, which is only reachable when HZ_PAUSE_HOLD_EN is defined.
package hz_pkg;

  localparam int          DIV_WIDTH_DEFAULT = 26;
  localparam int unsigned DEFAULT_DIV_1HZ   = 25_000_000;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    PAUSE = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hz_tick_prescaler.sv
// Programmable half-period divider producing the Hz square wave plus a one-cycle tick on each rising edge.
// Optional macro HZ_PAUSE_HOLD_EN: dropping enable freezes phase and count instead of stopping.
module hz_tick_prescaler
  import hz_pkg::*;
#(
  parameter int          DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1HZ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sync_clear,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 Hz,
  output logic                 tick,
  output logic                 running
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

  hz_state_e            state, state_d;
  logic [DIV_WIDTH-1:0] cnt, cnt_d;
  logic [DIV_WIDTH-1:0] shadow_div, shadow_d;
  logic [DIV_WIDTH-1:0] active_div, active_d;
  logic                 hz_q, hz_d;
  logic                 tick_q, tick_d;
  logic                 running_q, running_d;
  logic                 terminal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= STOP;
      cnt        <= '0;
      shadow_div <= DIV_RESET;
      active_div <= DIV_RESET;
      hz_q       <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      shadow_div <= shadow_d;
      active_div <= active_d;
      hz_q       <= hz_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
    end
  end

  // Phase boundaries copy shadow_d, not shadow_div, so a same-cycle load takes effect immediately.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    hz_d     = hz_q;
    tick_d   = 1'b0;
    active_d = active_div;
    shadow_d = shadow_div;
    terminal = (cnt == (active_div - DIV_ONE));

    if (div_load) begin
      shadow_d = (div_value == '0) ? DIV_ONE : div_value;
    end

    case (state)
      STOP: begin
        cnt_d = '0;
        hz_d  = 1'b0;
        if (enable) begin
          state_d  = LOW;
          active_d = shadow_d;
        end
      end

      LOW, HIGH: begin
        if (!enable) begin
`ifdef HZ_PAUSE_HOLD_EN
          state_d = PAUSE;
`else
          state_d = STOP;
          cnt_d   = '0;
          hz_d    = 1'b0;
`endif
        end else if (sync_clear) begin
          state_d  = LOW;
          cnt_d    = '0;
          hz_d     = 1'b0;
          active_d = shadow_d;
        end else if (terminal) begin
          cnt_d    = '0;
          active_d = shadow_d;
          if (state == LOW) begin
            state_d = HIGH;
            hz_d    = 1'b1;
            tick_d  = 1'b1;
          end else begin
            state_d = LOW;
            hz_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt + DIV_ONE;
        end
      end

      PAUSE: begin
`ifdef HZ_PAUSE_HOLD_EN
        // The held Hz level records which phase was frozen.
        if (sync_clear) begin
          state_d = STOP;
          cnt_d   = '0;
          hz_d    = 1'b0;
        end else if (enable) begin
          state_d = hz_q ? HIGH : LOW;
        end
`else
        state_d = STOP;
        cnt_d   = '0;
        hz_d    = 1'b0;
`endif
      end

      default: begin
        state_d = STOP;
        cnt_d   = '0;
        hz_d    = 1'b0;
      end
    endcase

    running_d = (state_d != STOP) && (state_d != PAUSE);
  end

  assign Hz      = hz_q;
  assign tick    = tick_q;
  assign running = running_q;

endmodule
